regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Sequencing controller that drives the one-hot read/write port of `gen_regs`, turning single register-level instructions into the select, enable and write-data pattern the register file expects. It accepts one instruction at a time over a valid/ready handshake, reads up to two operands through `selectR`/`selectR2`, computes a result, and commits it through `selectW`/`enable`. It sits between the instruction decoder and the register file; the register file's `out`/`out2` feed back into this block.

## Interface
- `WIDTH`, 8, data width; matches `gen_regs` `WIDTH`
- `SIZE`, 8, number of registers; one-hot select width; matches `gen_regs` `SIZE`
- `IDXW`, `$clog2(SIZE)`, register index width (derived; not overridden)

- `clk` input 1 — single clock; all state changes on the rising edge
- `reset` input 1 — asynchronous, active-low; `reset`=0 forces reset state immediately
- `instr_valid` input 1 — instruction fields are valid
- `instr_ready` output 1 — controller can accept an instruction
- `opcode` input 3 — operation, see Operation
- `rx` input IDXW — destination register and first source
- `ry` input IDXW — second source
- `imm` input WIDTH — immediate for LDI
- `rd_a` input WIDTH — from `gen_regs` `out`
- `rd_b` input WIDTH — from `gen_regs` `out2`
- `wr_data` output WIDTH — to `gen_regs` `in`
- `selectR` output SIZE — one-hot read select A
- `selectR2` output SIZE — one-hot read select B
- `selectW` output SIZE — one-hot write select
- `enable` output 1 — register-file write enable
- `done` output 1 — one-cycle pulse when an instruction retires
- `flag_z`, `flag_c` output 1 — present only with `REGFILE_CTRL_FLAGS_EN`

## Operation
- Opcodes: 0 NOP; 1 LDI rx←imm; 2 MOV rx←ry; 3 ADD rx←rx+ry; 4 SUB rx←rx−ry; 5 XOR rx←rx^ry; 6 INC rx←rx+1; 7 reserved, executed as NOP.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch opcode/rx/ry/imm. Next state: READ for MOV/ADD/SUB/XOR/INC, WRITE for LDI, DONE for NOP/reserved.
  - READ: `selectR`=1<<rx, `selectR2`=1<<ry; compute the result from `rd_a`/`rd_b` (combinational register-file read) and register it into `wr_data` at the end of the cycle. → WRITE.
  - WRITE: `selectW`=1<<rx, `enable`=1, `wr_data` holds the result; `gen_regs` captures on the edge ending this cycle. → DONE.
  - DONE: `done`=1. → IDLE.
- Outside their states: `selectR`, `selectR2`, `selectW` are all-zero and `enable`=0. `wr_data` holds its last value.
- Arithmetic is modulo 2^WIDTH. The carry-out (bit WIDTH) is kept only for the flags. SUB borrow: `flag_c`=1 when rx<ry (unsigned).
- Exactly one bit is set in any active select. rx≥SIZE (non-power-of-two SIZE) gives all-zero selects, so no register is written.
- The instruction fields are ignored except in the IDLE handshake cycle.

## Timing
- Reset values: `instr_ready`=0 while `reset`=0, then 1 from the first cycle after release (IDLE). `selectR`/`selectR2`/`selectW`=0, `enable`=0, `wr_data`=0, `done`=0, flags=0.
- If accept is at cycle n, the latency to `done` is:
  - ALU/MOV/INC: READ n+1, WRITE n+2, `done` n+3.
  - LDI: WRITE n+1, `done` n+2.
  - NOP/reserved: `done` n+1.
- Throughput: the next accept is possible in the cycle after `done` (IDLE). A `instr_valid` held high is accepted exactly once per IDLE visit.
- Reset asserted mid-instruction: the instruction is abandoned, outputs go to reset values asynchronously, and no `enable` pulse is issued after the reset.
- Instruction with rx==ry (e.g. ADD r3,r3): both read selects are set to the same bit, and the result is 2·r3.

## Configuration
- `REGFILE_CTRL_FLAGS_EN` defined:
  - Adds `flag_z` and `flag_c`, registered on the READ→WRITE edge for ADD/SUB/XOR/INC.
  - `flag_z`=(result==0). `flag_c`=carry for ADD/INC, borrow for SUB, 0 for XOR.
  - LDI/MOV/NOP leave the flags unchanged.
- Not defined: the ports and flag logic are absent; all other behaviour is identical.

## Test plan
- LDI rx=2, imm=0x5A accepted at cycle n: `selectW`=0x04 and `enable`=1 only in n+1, `wr_data`=0x5A, `done` in n+2, `selectR`/`selectR2`=0 throughout.
- ADD rx=1, ry=5, with the model returning `rd_a`=0xF0, `rd_b`=0x20: `selectR`=0x02 and `selectR2`=0x20 in n+1; `selectW`=0x02 with `wr_data`=0x10 in n+2; with the flags macro, `flag_c`=1 and `flag_z`=0.
- INC rx=7 with `rd_a`=0xFF: `wr_data`=0x00, `selectW`=0x80, `flag_z`=1, `flag_c`=1.
- `instr_valid` held high with two SUB instructions: `instr_ready`=0 in n+1..n+3, the second is accepted at n+4, and exactly two `enable` pulses occur.
- Reset low during WRITE: `enable` and `selectW` drop to 0 immediately; after release `instr_ready`=1 and no `done` pulse for the abandoned instruction.
- Opcode 7 and NOP: `done` at n+1, with no select bit and no `enable` asserted.

Source files
------------

// File: rtl/regfile_ctrl.sv
// Sequencer that turns single register-level instructions into gen_regs select/enable/data patterns.
// Optional Z/C flag outputs are built when REGFILE_CTRL_FLAGS_EN is defined.
module regfile_ctrl #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 8,
  parameter int IDXW  = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       opcode,
  input  logic [IDXW-1:0]  rx,
  input  logic [IDXW-1:0]  ry,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] rd_a,
  input  logic [WIDTH-1:0] rd_b,
  output logic [WIDTH-1:0] wr_data,
  output logic [SIZE-1:0]  selectR,
  output logic [SIZE-1:0]  selectR2,
  output logic [SIZE-1:0]  selectW,
  output logic             enable,
  output logic             done
`ifdef REGFILE_CTRL_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_c
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_INC = 3'd6;

  state_e           state_q, state_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [IDXW-1:0]  rx_q, rx_d;
  logic [IDXW-1:0]  ry_q, ry_d;
  logic [WIDTH-1:0] wrData_q, wrData_d;
  logic [WIDTH-1:0] aluResult;
`ifdef REGFILE_CTRL_FLAGS_EN
  logic             flagZ_q, flagZ_d;
  logic             flagC_q, flagC_d;
`endif

  // Indices past SIZE-1 match no bit, so they select nothing.
  function automatic logic [SIZE-1:0] oneHot(input logic [IDXW-1:0] idx);
    logic [SIZE-1:0] sel;
    sel = '0;
    for (int i = 0; i < SIZE; i++) begin
      sel[i] = (idx == IDXW'(i));
    end
    return sel;
  endfunction

  always_comb begin
    aluResult = rd_a;
    case (opcode_q)
      OP_MOV:  aluResult = rd_b;
      OP_ADD:  aluResult = rd_a + rd_b;
      OP_SUB:  aluResult = rd_a - rd_b;
      OP_XOR:  aluResult = rd_a ^ rd_b;
      OP_INC:  aluResult = rd_a + {{(WIDTH-1){1'b0}}, 1'b1};
      default: aluResult = rd_a;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    wrData_d    = wrData_q;
    selectR     = '0;
    selectR2    = '0;
    selectW     = '0;
    enable      = 1'b0;
    done        = 1'b0;
    instr_ready = reset && (state_q == IDLE);
`ifdef REGFILE_CTRL_FLAGS_EN
    flagZ_d     = flagZ_q;
    flagC_d     = flagC_q;
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          opcode_d = opcode;
          rx_d     = rx;
          ry_d     = ry;
          case (opcode)
            OP_LDI: begin
              wrData_d = imm;
              state_d  = WRITE;
            end
            OP_MOV, OP_ADD, OP_SUB, OP_XOR, OP_INC: state_d = READ;
            default: state_d = DONE;
          endcase
        end
      end
      READ: begin
        selectR  = oneHot(rx_q);
        selectR2 = oneHot(ry_q);
        wrData_d = aluResult;
`ifdef REGFILE_CTRL_FLAGS_EN
        // Carry for ADD is detected as wraparound of the truncated sum.
        case (opcode_q)
          OP_ADD: begin
            flagZ_d = (aluResult == '0);
            flagC_d = (aluResult < rd_a);
          end
          OP_SUB: begin
            flagZ_d = (aluResult == '0);
            flagC_d = (rd_a < rd_b);
          end
          OP_XOR: begin
            flagZ_d = (aluResult == '0);
            flagC_d = 1'b0;
          end
          OP_INC: begin
            flagZ_d = (aluResult == '0);
            flagC_d = (rd_a == '1);
          end
          default: ;
        endcase
`endif
        state_d = WRITE;
      end
      WRITE: begin
        selectW = oneHot(rx_q);
        enable  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      wrData_q <= '0;
`ifdef REGFILE_CTRL_FLAGS_EN
      flagZ_q  <= 1'b0;
      flagC_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      wrData_q <= wrData_d;
`ifdef REGFILE_CTRL_FLAGS_EN
      flagZ_q  <= flagZ_d;
      flagC_q  <= flagC_d;
`endif
    end
  end

  assign wr_data = wrData_q;
`ifdef REGFILE_CTRL_FLAGS_EN
  assign flag_z = flagZ_q;
  assign flag_c = flagC_q;
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a small behavioural gen_regs model on the read/write ports.
module tb_regfile_ctrl;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [7:0] imm;
  logic [7:0] rd_a;
  logic [7:0] rd_b;
  logic [7:0] wr_data;
  logic [7:0] selectR;
  logic [7:0] selectR2;
  logic [7:0] selectW;
  logic       enable;
  logic       done;
`ifdef REGFILE_CTRL_FLAGS_EN
  logic       flag_z;
  logic       flag_c;
`endif

  int nChecks = 0;
  int nFails = 0;
  int enablePulses = 0;
  int pulseBase;
  logic [7:0] regs [8] = '{default: 8'h00};

  regfile_ctrl #(.WIDTH(8), .SIZE(8)) dut (
    .clk(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode(opcode),
    .rx(rx),
    .ry(ry),
    .imm(imm),
    .rd_a(rd_a),
    .rd_b(rd_b),
    .wr_data(wr_data),
    .selectR(selectR),
    .selectR2(selectR2),
    .selectW(selectW),
    .enable(enable),
    .done(done)
`ifdef REGFILE_CTRL_FLAGS_EN
    ,
    .flag_z(flag_z),
    .flag_c(flag_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational one-hot reads, write on the rising edge.
  always_comb begin
    rd_a = 8'h00;
    rd_b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (selectR[i]) rd_a = regs[i];
      if (selectR2[i]) rd_b = regs[i];
    end
  end

  always @(posedge clk) begin
    if (enable) begin
      enablePulses = enablePulses + 1;
      for (int i = 0; i < 8; i++) begin
        if (selectW[i]) regs[i] = wr_data;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkFlags(input string tag, input logic expZ, input logic expC);
`ifdef REGFILE_CTRL_FLAGS_EN
    checkOutput({tag, "_z"}, {31'd0, flag_z}, {31'd0, expZ});
    checkOutput({tag, "_c"}, {31'd0, flag_c}, {31'd0, expC});
`else
    if (expZ === 1'bx && expC === 1'bx) $display("[TB] flags not built");
`endif
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) checkOutput("readyTimeout", 32'd0, 32'd1);
  endtask

  // Presents one instruction in an IDLE cycle; returns just after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                               input logic [7:0] value);
    waitReady();
    opcode = op;
    rx = x;
    ry = y;
    imm = value;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic loadReg(input logic [2:0] x, input logic [7:0] value);
    applyStimulus(3'd1, x, 3'd0, value);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ldiDone", {31'd0, done}, 32'd1);
  endtask

  task automatic runAlu(input string tag, input logic [2:0] op, input logic [2:0] x,
                        input logic [2:0] y, input logic [7:0] result,
                        input logic expZ, input logic expC);
    applyStimulus(op, x, y, 8'h00);
    @(negedge clk);
    checkOutput({tag, "_selR"}, {24'd0, selectR}, {24'd0, 8'h01 << x});
    checkOutput({tag, "_selR2"}, {24'd0, selectR2}, {24'd0, 8'h01 << y});
    checkOutput({tag, "_enRead"}, {31'd0, enable}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_selW"}, {24'd0, selectW}, {24'd0, 8'h01 << x});
    checkOutput({tag, "_en"}, {31'd0, enable}, 32'd1);
    checkOutput({tag, "_data"}, {24'd0, wr_data}, {24'd0, result});
    checkFlags(tag, expZ, expC);
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_reg"}, {24'd0, regs[x]}, {24'd0, result});
  endtask

  initial begin
    reset = 1'b0;
    instr_valid = 1'b0;
    opcode = 3'd0;
    rx = 3'd0;
    ry = 3'd0;
    imm = 8'h00;

    #12;
    checkOutput("rstReady", {31'd0, instr_ready}, 32'd0);
    checkOutput("rstSel", {8'd0, selectR, selectR2, selectW}, 32'd0);
    checkOutput("rstEnable", {31'd0, enable}, 32'd0);
    checkOutput("rstData", {24'd0, wr_data}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkFlags("rst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterRst", {31'd0, instr_ready}, 32'd1);

    applyStimulus(3'd1, 3'd2, 3'd0, 8'h5A);
    @(negedge clk);
    checkOutput("ldiSelW", {24'd0, selectW}, 32'h04);
    checkOutput("ldiEn", {31'd0, enable}, 32'd1);
    checkOutput("ldiData", {24'd0, wr_data}, 32'h5A);
    checkOutput("ldiSelR", {16'd0, selectR, selectR2}, 32'd0);
    checkOutput("ldiReady", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    checkOutput("ldiDone", {31'd0, done}, 32'd1);
    checkOutput("ldiEnOff", {31'd0, enable}, 32'd0);
    checkOutput("ldiSelAll", {8'd0, selectR, selectR2, selectW}, 32'd0);
    checkOutput("ldiReg", {24'd0, regs[2]}, 32'h5A);
    checkFlags("ldi", 1'b0, 1'b0);

    loadReg(3'd1, 8'hF0);
    loadReg(3'd5, 8'h20);
    loadReg(3'd7, 8'hFF);
    loadReg(3'd3, 8'h50);
    loadReg(3'd4, 8'h30);

    runAlu("add", 3'd3, 3'd1, 3'd5, 8'h10, 1'b0, 1'b1);
    runAlu("inc", 3'd6, 3'd7, 3'd0, 8'h00, 1'b1, 1'b1);
    runAlu("mov", 3'd2, 3'd0, 3'd2, 8'h5A, 1'b1, 1'b1);

    // Back-to-back SUBs with instr_valid held high.
    pulseBase = enablePulses;
    waitReady();
    opcode = 3'd4;
    rx = 3'd3;
    ry = 3'd4;
    instr_valid = 1'b1;
    @(negedge clk);
    checkOutput("holdReady1", {31'd0, instr_ready}, 32'd0);
    opcode = 3'd1;
    rx = 3'd7;
    imm = 8'hEE;
    @(negedge clk);
    checkOutput("holdReady2", {31'd0, instr_ready}, 32'd0);
    checkOutput("sub1Data", {24'd0, wr_data}, 32'h20);
    checkFlags("sub1", 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("holdReady3", {31'd0, instr_ready}, 32'd0);
    checkOutput("sub1Done", {31'd0, done}, 32'd1);
    opcode = 3'd4;
    rx = 3'd3;
    ry = 3'd4;
    @(negedge clk);
    checkOutput("holdReady4", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("sub2SelR", {16'd0, selectR, selectR2}, 32'h0810);
    @(negedge clk);
    checkOutput("sub2Data", {24'd0, wr_data}, 32'hF0);
    checkFlags("sub2", 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("sub2Done", {31'd0, done}, 32'd1);
    checkOutput("subPulses", enablePulses - pulseBase, 32'd2);
    checkOutput("subReg7", {24'd0, regs[7]}, 32'h00);

    runAlu("addSame", 3'd3, 3'd3, 3'd3, 8'hE0, 1'b0, 1'b1);
    runAlu("xor", 3'd5, 3'd2, 3'd2, 8'h00, 1'b1, 1'b0);

    // Abandon an LDI in its WRITE cycle.
    applyStimulus(3'd1, 3'd6, 3'd0, 8'hAA);
    @(negedge clk);
    checkOutput("abortEnBefore", {31'd0, enable}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abortEn", {31'd0, enable}, 32'd0);
    checkOutput("abortSelW", {24'd0, selectW}, 32'd0);
    checkOutput("abortReady", {31'd0, instr_ready}, 32'd0);
    checkOutput("abortData", {24'd0, wr_data}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abortNoDone", {31'd0, done}, 32'd0);
      checkOutput("abortIdleReady", {31'd0, instr_ready}, 32'd1);
    end
    checkOutput("abortReg6", {24'd0, regs[6]}, 32'h00);
    checkFlags("abort", 1'b0, 1'b0);

    pulseBase = enablePulses;
    applyStimulus(3'd7, 3'd1, 3'd2, 8'h33);
    @(negedge clk);
    checkOutput("op7Done", {31'd0, done}, 32'd1);
    checkOutput("op7Sel", {8'd0, selectR, selectR2, selectW}, 32'd0);
    checkOutput("op7En", {31'd0, enable}, 32'd0);
    applyStimulus(3'd0, 3'd4, 3'd5, 8'h44);
    @(negedge clk);
    checkOutput("nopDone", {31'd0, done}, 32'd1);
    checkOutput("nopSel", {8'd0, selectR, selectR2, selectW}, 32'd0);
    @(negedge clk);
    checkOutput("nopReady", {31'd0, instr_ready}, 32'd1);
    checkOutput("nopPulses", enablePulses - pulseBase, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
